// File: rtl/pc_stack_register.sv
// Program-counter register with load/inc/call/ret modes and a DEPTH-entry
// hardware return-address stack with sticky overflow/underflow flags.
module pc_stack_register #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] INC_STEP  = WIDTH'(1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       load_i,
  input  logic                       inc_i,
  input  logic                       call_i,
  input  logic                       ret_i,
  input  logic                       err_clr_i,
  input  logic [WIDTH-1:0]           d_i,
  output logic [WIDTH-1:0]           q_o,
  output logic [$clog2(DEPTH+1)-1:0] sp_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       ovf_o,
  output logic                       unf_o
);

  localparam int unsigned SW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [SW-1:0]    sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic             full, empty;
  logic             do_ret, do_call, do_load, do_inc;
  logic             ret_ok, ret_err, call_ok, call_err;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] stack_top;

  assign full  = (sp_q == SW'(DEPTH));
  assign empty = (sp_q == '0);

  // One mode per cycle: ret > call > load > inc.
  assign do_ret  = en_i & ret_i;
  assign do_call = en_i & ~ret_i & call_i;
  assign do_load = en_i & ~ret_i & ~call_i & load_i;
  assign do_inc  = en_i & ~ret_i & ~call_i & ~load_i & inc_i;

  assign ret_ok   = do_ret & ~empty;
  assign ret_err  = do_ret & empty;
  assign call_ok  = do_call & ~full;
  assign call_err = do_call & full;

  assign inc_val = q_q + INC_STEP;

  always_comb begin
    stack_top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sp_q == SW'(i + 1)) begin
        stack_top = stack_q[i];
      end
    end
  end

  always_comb begin
    q_d = q_q;
    if (ret_ok) begin
      q_d = stack_top;
    end else if (call_ok || do_load) begin
      q_d = d_i;
    end else if (do_inc) begin
      q_d = inc_val;
    end
  end

  always_comb begin
    sp_d = sp_q;
    if (ret_ok) begin
      sp_d = sp_q - SW'(1);
    end else if (call_ok) begin
      sp_d = sp_q + SW'(1);
    end
  end

  always_comb begin
    stack_d = stack_q;
    if (call_ok) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (sp_q == SW'(i)) begin
          stack_d[i] = inc_val;
        end
      end
    end
  end

  // A new error event outranks a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clr_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (call_err) begin
      ovf_d = 1'b1;
    end
    if (ret_err) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      q_q   <= RESET_VAL;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      q_q     <= q_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stack_q <= stack_d;
    end
  end

  assign q_o     = q_q;
  assign sp_o    = sp_q;
  assign full_o  = full;
  assign empty_o = empty;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: tb/tb_pc_stack_register.sv
// Randomized bench for pc_stack_register against a queue-based model of the
// return stack, plus directed scenarios pinned with literal expectations.
module tb_pc_stack_register;

  localparam int unsigned      WIDTH = 16;
  localparam int unsigned      DEPTH = 4;
  localparam logic [WIDTH-1:0] RVAL  = 16'h0100;
  localparam int unsigned      SW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0, load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0, clr = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic [WIDTH-1:0] q;
  logic [SW-1:0]    sp;
  logic             full, empty, ovf, unf;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // Behavioural model
  logic [WIDTH-1:0] m_q = RVAL;
  logic [WIDTH-1:0] m_stk[$];
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;

  pc_stack_register #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_VAL(RVAL),
    .INC_STEP (16'd1)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .load_i   (load),
    .inc_i    (inc),
    .call_i   (call),
    .ret_i    (ret),
    .err_clr_i(clr),
    .d_i      (d),
    .q_o      (q),
    .sp_o     (sp),
    .full_o   (full),
    .empty_o  (empty),
    .ovf_o    (ovf),
    .unf_o    (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q = RVAL;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit l, input bit i, input bit c, input bit r,
                            input bit x, input logic [WIDTH-1:0] dv);
    if (x) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (e) begin
      if (r) begin
        if (m_stk.size() == 0) m_unf = 1'b1;
        else m_q = m_stk.pop_back();
      end else if (c) begin
        if (m_stk.size() == DEPTH) m_ovf = 1'b1;
        else begin
          m_stk.push_back(m_q + 16'd1);
          m_q = dv;
        end
      end else if (l) begin
        m_q = dv;
      end else if (i) begin
        m_q = m_q + 16'd1;
      end
    end
  endtask

  // Entered at posedge+1; returns at the next posedge+1 with the model updated.
  task automatic step(input bit e, input bit l, input bit i, input bit c, input bit r,
                      input bit x, input logic [WIDTH-1:0] dv);
    en = e; load = l; inc = i; call = c; ret = r; clr = x; d = dv;
    @(posedge clk);
    model_step(e, l, i, c, r, x, dv);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Asynchronous reset pulse entered and left away from any clock edge.
  task automatic pulse_reset();
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_q", q, RVAL);
    chk("rst_sp", sp, 0);
    chk("rst_empty", empty, 1);
    #1 rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("q", q, m_q);
      chk("sp", sp, m_stk.size());
      chk("full", full, m_stk.size() == DEPTH);
      chk("empty", empty, m_stk.size() == 0);
      chk("ovf", ovf, m_ovf);
      chk("unf", unf, m_unf);
    end
  end

  initial begin
    #12 rst = 1'b1;
    chk_on = 1'b1;
    chk("init_q", q, RVAL);
    @(posedge clk); #1;

    // Reset/idle
    step(1, 1, 0, 0, 0, 0, 16'h1234);
    pulse_reset();
    repeat (3) idle();
    chk("idle_q", q, 16'h0100);

    // Load/inc/wrap
    step(1, 1, 0, 0, 0, 0, 16'hFFFE); chk("ld_q", q, 16'hFFFE);
    step(1, 0, 1, 0, 0, 0, '0);       chk("inc1_q", q, 16'hFFFF);
    step(1, 0, 1, 0, 0, 0, '0);       chk("inc2_q", q, 16'h0000);
    step(1, 0, 1, 0, 0, 0, '0);       chk("inc3_q", q, 16'h0001);
    step(0, 0, 1, 0, 0, 0, '0);       chk("dis_q", q, 16'h0001);

    // Nested call/ret
    step(1, 1, 0, 0, 0, 0, 16'h0010);
    step(1, 0, 0, 1, 0, 0, 16'h0200);
    step(1, 0, 0, 1, 0, 0, 16'h0300);
    chk("call2_q", q, 16'h0300); chk("call2_sp", sp, 2);
    step(1, 0, 0, 0, 1, 0, '0);  chk("ret1_q", q, 16'h0201); chk("ret1_sp", sp, 1);
    step(1, 0, 0, 0, 1, 0, '0);  chk("ret2_q", q, 16'h0011); chk("ret2_sp", sp, 0);

    // Overflow
    for (int k = 0; k < 4; k++) step(1, 0, 0, 1, 0, 0, 16'h1000 + 16'(k));
    chk("fill_full", full, 1);
    step(1, 0, 0, 1, 0, 0, 16'hBEEF);
    chk("ovf_q", q, 16'h1003); chk("ovf_sp", sp, 4); chk("ovf_flag", ovf, 1);
    step(0, 0, 0, 0, 0, 1, '0);  chk("ovf_clr", ovf, 0);
    repeat (4) step(1, 0, 0, 0, 1, 0, '0);
    chk("unwind_q", q, 16'h0012);

    // Underflow plus simultaneous events
    step(1, 1, 0, 0, 1, 0, 16'h5555);
    chk("unf_q", q, 16'h0012); chk("unf_flag", unf, 1);
    step(1, 0, 0, 0, 1, 1, '0);  chk("unf_setwins", unf, 1);
    step(1, 0, 0, 0, 0, 1, '0);  chk("unf_clr", unf, 0);

    // Priority, then reset during a call cycle
    step(1, 1, 0, 0, 0, 0, 16'h0020);
    step(1, 1, 1, 1, 0, 0, 16'h0400);
    chk("pri_q", q, 16'h0400); chk("pri_sp", sp, 1);
    step(1, 0, 0, 0, 1, 0, '0);  chk("pri_top", q, 16'h0021);
    step(1, 1, 0, 0, 0, 0, 16'h0020);
    en = 1; load = 1; inc = 1; call = 1; d = 16'h0400;
    pulse_reset();
    idle();
    chk("midrst_sp", sp, 0); chk("midrst_q", q, RVAL);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
        idle();
      end else begin
        step($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 2) == 0), $urandom_range(0, 9) == 0, 16'($urandom));
      end
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
